// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch predictor / resolve pair: fall-through step
// and the MIPS opcode/funct encodings used by pre-decode.
package branch_resolve_unit_pkg;
  localparam int unsigned BRU_PC_STEP = 4;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        sel;
    logic [31:0] pbjpc;
  } id_reg_t;

  function automatic logic is_bj(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) ||
           ((op == OP_SPECIAL) && (fn == FN_JR));
  endfunction
endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter for performance statistics.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      value <= '0;
    else if (inc && value != '1)  value <= value + 1'b1;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: checks the IF prediction against the real
// outcome, drives predictor/BTB updates and the fetch redirect.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int unsigned PC_STEP = BRU_PC_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_if,
  input  logic             sel_bj_pc,
  input  logic [31:0]      pre_bjpc,
  input  logic             if_valid,
  input  logic             stall_id,
  input  logic             flush_ext,
  input  logic             id_is_branch,
  input  logic             id_is_jump,
  input  logic             id_cond_true,
  input  logic [31:0]      id_target,
  output logic [31:0]      pc_id,
  output logic             real_br_taken,
  output logic [31:0]      real_bjpc,
  output logic             ud_pdt,
  output logic             ud_BTB,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);
  id_reg_t id_q;
  logic    act, taken, tgt_diff, mis;

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                     id_q <= '0;
    else if (flush_ext || flush_if) id_q.vld <= 1'b0;
    else if (!stall_id)            id_q <= '{vld: if_valid, pc: pc_if, sel: sel_bj_pc, pbjpc: pre_bjpc};
  end

  // stalls defer resolution so a held entry is acted on exactly once
  assign act      = id_q.vld & ~stall_id & ~flush_ext;
  assign taken    = id_is_jump | (id_is_branch & id_cond_true);
  assign tgt_diff = id_q.pbjpc != id_target;
  assign mis      = (taken != id_q.sel) | (taken & id_q.sel & tgt_diff);

  assign pc_id         = id_q.pc;
  assign real_br_taken = taken;
  assign real_bjpc     = id_target;
  assign ud_pdt        = act & id_is_branch;
  assign ud_BTB        = act & taken & (~id_q.sel | tgt_diff);
  assign redirect      = act & mis;
  assign flush_if      = redirect;
  assign redirect_pc   = taken ? id_target : id_q.pc + 32'(PC_STEP);

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .rst(rst_n), .inc(act & (id_is_branch | id_is_jump)), .value(br_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk(clk), .rst(rst_n), .inc(act & mis), .value(mis_cnt)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a CNT_W=4 copy shares the stimulus
// to exercise counter saturation.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if, pre_bjpc, id_target;
  logic        sel_bj_pc, if_valid, stall_id, flush_ext;
  logic        id_is_branch, id_is_jump, id_cond_true;

  logic [31:0] pc_id, real_bjpc, redirect_pc;
  logic        real_br_taken, ud_pdt, ud_BTB, redirect, flush_if;
  logic [31:0] br_cnt, mis_cnt;

  logic [31:0] pc_id4, real_bjpc4, redirect_pc4;
  logic        real_br_taken4, ud_pdt4, ud_BTB4, redirect4, flush_if4;
  logic [3:0]  br_cnt4, mis_cnt4;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .sel_bj_pc(sel_bj_pc), .pre_bjpc(pre_bjpc),
    .if_valid(if_valid), .stall_id(stall_id), .flush_ext(flush_ext),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_cond_true(id_cond_true),
    .id_target(id_target), .pc_id(pc_id), .real_br_taken(real_br_taken),
    .real_bjpc(real_bjpc), .ud_pdt(ud_pdt), .ud_BTB(ud_BTB), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .sel_bj_pc(sel_bj_pc), .pre_bjpc(pre_bjpc),
    .if_valid(if_valid), .stall_id(stall_id), .flush_ext(flush_ext),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_cond_true(id_cond_true),
    .id_target(id_target), .pc_id(pc_id4), .real_br_taken(real_br_taken4),
    .real_bjpc(real_bjpc4), .ud_pdt(ud_pdt4), .ud_BTB(ud_BTB4), .redirect(redirect4),
    .redirect_pc(redirect_pc4), .flush_if(flush_if4), .br_cnt(br_cnt4), .mis_cnt(mis_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic sel, input logic [31:0] pbj);
    if_valid = 1'b1; pc_if = pc; sel_bj_pc = sel; pre_bjpc = pbj;
  endtask

  task automatic idle_if();
    if_valid = 1'b0; pc_if = '0; sel_bj_pc = 1'b0; pre_bjpc = '0;
  endtask

  task automatic set_id(input logic br, input logic jp, input logic ct, input logic [31:0] tgt);
    id_is_branch = br; id_is_jump = jp; id_cond_true = ct; id_target = tgt;
  endtask

  initial begin
    rst_n = 1'b1; stall_id = 1'b0; flush_ext = 1'b0;
    idle_if(); set_id(0, 0, 0, '0);
    #12;
    // reset state
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_taken", 32'(real_br_taken), 0);
    chk("rst_ud_pdt", 32'(ud_pdt), 0);
    chk("rst_ud_btb", 32'(ud_BTB), 0);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_flush_if", 32'(flush_if), 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_mis_cnt", mis_cnt, 0);
    tick(); rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_strobes", {29'b0, ud_pdt, ud_BTB, redirect}, 0);
    end

    // beq predicted not-taken, actually taken
    fetch(32'h100, 0, 0);
    tick(); idle_if(); set_id(1, 0, 1, 32'h140); #1;
    chk("beq_pc_id", pc_id, 32'h100);
    chk("beq_redirect", 32'(redirect), 1);
    chk("beq_flush_if", 32'(flush_if), 1);
    chk("beq_redirect_pc", redirect_pc, 32'h140);
    chk("beq_ud_pdt", 32'(ud_pdt), 1);
    chk("beq_ud_btb", 32'(ud_BTB), 1);
    chk("beq_taken", 32'(real_br_taken), 1);
    chk("beq_real_bjpc", real_bjpc, 32'h140);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("beq_after_ud_pdt", 32'(ud_pdt), 0);
    chk("beq_after_redirect", 32'(redirect), 0);
    chk("beq_br_cnt", br_cnt, 1);
    chk("beq_mis_cnt", mis_cnt, 1);

    // bne predicted taken, actually not taken
    fetch(32'h200, 1, 32'h240);
    tick(); idle_if(); set_id(1, 0, 0, 32'h240); #1;
    chk("bne_redirect", 32'(redirect), 1);
    chk("bne_redirect_pc", redirect_pc, 32'h204);
    chk("bne_taken", 32'(real_br_taken), 0);
    chk("bne_ud_pdt", 32'(ud_pdt), 1);
    chk("bne_ud_btb", 32'(ud_BTB), 0);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("bne_br_cnt", br_cnt, 2);
    chk("bne_mis_cnt", mis_cnt, 2);

    // jump with stale BTB target, then with matching target
    fetch(32'h300, 1, 32'h380);
    tick(); idle_if(); set_id(0, 1, 0, 32'h390); #1;
    chk("j_bad_redirect", 32'(redirect), 1);
    chk("j_bad_redirect_pc", redirect_pc, 32'h390);
    chk("j_bad_ud_btb", 32'(ud_BTB), 1);
    chk("j_bad_ud_pdt", 32'(ud_pdt), 0);
    tick(); set_id(0, 0, 0, '0); fetch(32'h300, 1, 32'h390);
    tick(); idle_if(); set_id(0, 1, 0, 32'h390); #1;
    chk("j_ok_redirect", 32'(redirect), 0);
    chk("j_ok_ud_btb", 32'(ud_BTB), 0);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("j_br_cnt", br_cnt, 4);
    chk("j_mis_cnt", mis_cnt, 3);

    // correctly predicted beq held by a 3-cycle stall
    fetch(32'h400, 0, 0);
    tick(); idle_if(); set_id(1, 0, 0, 32'h480); stall_id = 1'b1; #1;
    chk("stall0_ud_pdt", 32'(ud_pdt), 0);
    tick(); chk("stall1_ud_pdt", 32'(ud_pdt), 0);
    chk("stall1_pc_id", pc_id, 32'h400);
    tick(); chk("stall2_ud_pdt", 32'(ud_pdt), 0);
    tick(); stall_id = 1'b0; #1;
    chk("unstall_ud_pdt", 32'(ud_pdt), 1);
    chk("unstall_redirect", 32'(redirect), 0);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("unstall_after_ud_pdt", 32'(ud_pdt), 0);
    chk("stall_br_cnt", br_cnt, 5);
    chk("stall_mis_cnt", mis_cnt, 3);

    // external flush while stalled kills the entry
    fetch(32'h500, 0, 0);
    tick(); idle_if(); set_id(1, 0, 1, 32'h540); stall_id = 1'b1; #1;
    chk("fl_stall_ud_pdt", 32'(ud_pdt), 0);
    tick(); flush_ext = 1'b1; #1;
    chk("fl_ud_pdt", 32'(ud_pdt), 0);
    chk("fl_redirect", 32'(redirect), 0);
    tick(); flush_ext = 1'b0; stall_id = 1'b0; #1;
    chk("fl_after_ud_pdt", 32'(ud_pdt), 0);
    chk("fl_after_redirect", 32'(redirect), 0);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("fl_br_cnt", br_cnt, 5);
    chk("fl_mis_cnt", mis_cnt, 3);

    // BTB alias on a non-branch instruction
    fetch(32'h600, 1, 32'h700);
    tick(); idle_if(); #1;
    chk("alias_redirect", 32'(redirect), 1);
    chk("alias_redirect_pc", redirect_pc, 32'h604);
    chk("alias_ud_btb", 32'(ud_BTB), 0);
    chk("alias_ud_pdt", 32'(ud_pdt), 0);
    tick();
    chk("alias_br_cnt", br_cnt, 5);
    chk("alias_mis_cnt", mis_cnt, 4);

    // fall-through wraps at the top of the address space
    fetch(32'hFFFF_FFFC, 0, 0);
    tick(); idle_if(); set_id(1, 0, 0, 32'h10); #1;
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_redirect", 32'(redirect), 0);
    tick(); set_id(0, 0, 0, '0); #1;
    chk("wrap_br_cnt", br_cnt, 6);

    // reset mid-resolution clears immediately
    fetch(32'h700, 0, 0);
    tick(); idle_if(); set_id(1, 0, 1, 32'h740); #1;
    chk("pre_rst_redirect", 32'(redirect), 1);
    rst_n = 1'b1; #1;
    chk("mid_rst_redirect", 32'(redirect), 0);
    chk("mid_rst_ud_pdt", 32'(ud_pdt), 0);
    chk("mid_rst_br_cnt", br_cnt, 0);
    chk("mid_rst_mis_cnt", mis_cnt, 0);
    tick(); rst_n = 1'b0; set_id(0, 0, 0, '0);

    // 17 mispredicts: 4-bit counters saturate at 15
    for (int i = 0; i < 17; i++) begin
      fetch(32'h800, 0, 0);
      tick(); idle_if(); set_id(1, 0, 1, 32'h840);
      tick(); set_id(0, 0, 0, '0);
    end
    #1;
    chk("sat4_mis_cnt", 32'(mis_cnt4), 15);
    chk("sat4_br_cnt", 32'(br_cnt4), 15);
    chk("sat32_mis_cnt", mis_cnt, 17);
    chk("sat32_br_cnt", br_cnt, 17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
